// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage core: stall merge, exception flush/redirect,
// post-flush recovery masking, stall watchdog and saturating perf counters.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
  parameter int unsigned RECOVER_CYCLES = 2,
  parameter int unsigned TIMEOUT        = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  input  logic        wdog_clr,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [3:0]     RC_LOAD = 4'(RECOVER_CYCLES - 1);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t         r_state;
  logic [3:0]     r_rcnt;
  logic [WDW-1:0] r_wd;
  logic           r_timeout;
  logic [31:0]    r_stall_cycles;
  logic [15:0]    r_flush_count;

  logic           w_exc;
  logic           w_id;
  logic           w_ex;
  logic [5:0]     w_stall;
  logic [31:0]    w_new_pc;
  logic           w_stalled;

  // rst_n gates the combinational outputs so they read 0 during reset
  assign w_exc = rst_n && (excepttype != 32'h0);
  assign w_id  = stallreq_id && (r_state == RUN);
  assign w_ex  = stallreq_ex && (r_state == RUN);

  always_comb begin
    w_stall  = '0;
    w_new_pc = '0;
    if (!rst_n) begin
      w_stall = '0;
    end else if (w_exc) begin
      w_new_pc = (excepttype == 32'h0000_000e) ? cp0_epc : EXC_VECTOR;
    end else if (stallreq_mem) begin
      w_stall = 6'b011111;
    end else if (w_ex) begin
      w_stall = 6'b001111;
    end else if (w_id) begin
      w_stall = 6'b000111;
    end
  end

  assign w_stalled = (w_stall != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_rcnt         <= '0;
      r_wd           <= '0;
      r_timeout      <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_exc) begin
        r_state <= RECOVER;
        r_rcnt  <= RC_LOAD;
      end else if (r_state == RECOVER) begin
        if (r_rcnt == '0) r_state <= RUN;
        else              r_rcnt  <= r_rcnt - 4'd1;
      end

      if (w_exc || !w_stalled) r_wd <= '0;
      else if (r_wd != WD_MAX) r_wd <= r_wd + 1'b1;

      // flag sets only on the edge where the count first reaches TIMEOUT
      if (w_stalled && !w_exc && r_wd == WD_LAST) r_timeout <= 1'b1;
      else if (wdog_clr)                          r_timeout <= 1'b0;

      if (w_stalled && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_exc && r_flush_count != '1)      r_flush_count  <= r_flush_count + 16'd1;
    end
  end

  assign stall         = w_stall;
  assign flush         = w_exc;
  assign new_pc        = w_new_pc;
  assign stall_timeout = r_timeout;
  assign stall_cycles  = r_stall_cycles;
  assign flush_count   = r_flush_count;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (TIMEOUT=8, RECOVER_CYCLES=2).
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic        wdog_clr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  int unsigned n_checks;
  int unsigned n_fail;

  pipe_ctrl #(
    .EXC_VECTOR    (32'h0000_0020),
    .RECOVER_CYCLES(2),
    .TIMEOUT       (8)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excepttype   (excepttype),
    .cp0_epc      (cp0_epc),
    .wdog_clr     (wdog_clr),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall_timeout(stall_timeout),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one edge, then drive/settle time away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic ex, input logic mem, input logic [31:0] exc);
    stallreq_id  = id;
    stallreq_ex  = ex;
    stallreq_mem = mem;
    excepttype   = exc;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    wdog_clr = 1'b0;
    cp0_epc = 32'h0;
    drive(1'b0, 1'b0, 1'b1, 32'h8);
    chk("rst_stall", {26'h0, stall}, 32'h0);
    chk("rst_flush", {31'h0, flush}, 32'h0);
    chk("rst_newpc", new_pc, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_sc", stall_cycles, 32'h0);
    chk("rst_fc", {16'h0, flush_count}, 32'h0);
    chk("rst_to", {31'h0, stall_timeout}, 32'h0);

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_stall", {26'h0, stall}, 32'h0);
      chk("idle_flush", {31'h0, flush}, 32'h0);
    end
    chk("idle_sc", stall_cycles, 32'h0);

    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("idex_stall", {26'h0, stall}, 32'h0000_000f);
    tick();
    chk("sc1", stall_cycles, 32'd1);
    drive(1'b1, 1'b1, 1'b1, 32'h0);
    chk("mem_stall", {26'h0, stall}, 32'h0000_001f);
    tick();
    chk("sc2", stall_cycles, 32'd2);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("id_only_off", {26'h0, stall}, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("id_stall", {26'h0, stall}, 32'h0000_0007);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    drive(1'b0, 1'b0, 1'b1, 32'h8);
    chk("exc_flush", {31'h0, flush}, 32'h1);
    chk("exc_stall", {26'h0, stall}, 32'h0);
    chk("exc_newpc", new_pc, 32'h0000_0020);
    tick();
    chk("fc1", {16'h0, flush_count}, 32'd1);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rec1_mask", {26'h0, stall}, 32'h0);
    tick();
    chk("rec2_mask", {26'h0, stall}, 32'h0);
    tick();
    chk("rec_done", {26'h0, stall}, 32'h0000_000f);
    tick();
    chk("sc3", stall_cycles, 32'd3);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    cp0_epc = 32'hBFC0_0100;
    drive(1'b0, 1'b0, 1'b0, 32'he);
    chk("eret_flush", {31'h0, flush}, 32'h1);
    chk("eret_newpc", new_pc, 32'hBFC0_0100);
    tick();
    chk("fc2", {16'h0, flush_count}, 32'd2);
    drive(1'b0, 1'b1, 1'b1, 32'h0);
    chk("rec_mem_unmasked", {26'h0, stall}, 32'h0000_001f);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h8);
    chk("exc2_flush", {31'h0, flush}, 32'h1);
    chk("exc2_newpc", new_pc, 32'h0000_0020);
    tick();
    chk("fc3", {16'h0, flush_count}, 32'd3);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("restart1_mask", {26'h0, stall}, 32'h0);
    tick();
    chk("restart2_mask", {26'h0, stall}, 32'h0);
    tick();
    chk("restart_done", {26'h0, stall}, 32'h0000_000f);
    tick();
    chk("sc5", stall_cycles, 32'd5);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    drive(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("wd_run", {31'h0, stall_timeout}, (i == 8) ? 32'h1 : 32'h0);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("wd_sticky", {31'h0, stall_timeout}, 32'h1);
    wdog_clr = 1'b1;
    tick();
    chk("wd_clr", {31'h0, stall_timeout}, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("wd_setwins", {31'h0, stall_timeout}, (i == 8) ? 32'h1 : 32'h0);
    end
    wdog_clr = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("sc21", stall_cycles, 32'd21);

    drive(1'b0, 1'b0, 1'b0, 32'h8);
    tick();
    chk("fc4", {16'h0, flush_count}, 32'd4);
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    chk("pre_rst_stall", {26'h0, stall}, 32'h0000_001f);
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", {26'h0, stall}, 32'h0);
    chk("midrst_flush", {31'h0, flush}, 32'h0);
    chk("midrst_sc", stall_cycles, 32'h0);
    chk("midrst_fc", {16'h0, flush_count}, 32'h0);
    chk("midrst_to", {31'h0, stall_timeout}, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_run", {26'h0, stall}, 32'h0000_000f);
    tick();
    chk("post_rst_sc", stall_cycles, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
